cache_line_ctrl: RTL and testbench

//  Refill sequencer for a bank of NLINES cache lines. Detects a request that misses in every line,

---
 rtl/cache_line_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_line_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_ctrl
//  Purpose  : Refill sequencer and memory-port arbiter for a bank of cache lines.
//  Revision : 1.0 - initial release
// ============================================================================

module cache_line_ctrl #(
    parameter int NLINES   = 4,
    parameter int IDXBITS  = 2,
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int LSBBITS  = 7,
    parameter int TTLBITS  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic                         miss_valid,
    input  logic [ADDRBITS-1:0]          miss_addr,
    output logic                         miss_busy,
    output logic                         miss_done,

    input  logic [NLINES-1:0]            line_miss,
    input  logic [NLINES-1:0]            line_dirty,
    input  logic [NLINES-1:0]            line_ready,
    input  logic [NLINES*TTLBITS-1:0]    line_ttl,
    output logic [NLINES-1:0]            line_flush,
    output logic [NLINES-1:0]            line_fill,
    output logic [NLINES-1:0]            line_pause,
    output logic [ADDRBITS-1:0]          new_region,

    input  logic [NLINES*ADDRBITS-1:0]   line_mem_addr,
    input  logic [NLINES*DATABITS-1:0]   line_mem_out,
    input  logic [NLINES-1:0]            line_mem_rdreq,
    input  logic [NLINES-1:0]            line_mem_wrreq,
    output logic [DATABITS-1:0]          line_mem_in,
    output logic [NLINES-1:0]            line_mem_in_valid,

    output logic [ADDRBITS-1:0]          mem_addr,
    output logic [DATABITS-1:0]          mem_out,
    output logic                         mem_rdreq,
    output logic                         mem_wrreq,
    input  logic [DATABITS-1:0]          mem_in,
    input  logic                         mem_in_valid,
    input  logic                         mem_pause
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SELECT     = 3'd1,
        S_ISSUE      = 3'd2,
        S_WAIT_BUSY  = 3'd3,
        S_WAIT_READY = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t                r_state;
    logic [IDXBITS-1:0]    r_victim;
    logic [NLINES-1:0]     r_fill;
    logic [NLINES-1:0]     r_flush;
    logic                  r_done;
    logic                  r_busy;
    logic [ADDRBITS-1:0]   r_new_region;

    logic [IDXBITS-1:0]    w_min_idx;
    logic [TTLBITS-1:0]    w_min_ttl;
    logic [NLINES-1:0]     w_min_onehot;
    logic [NLINES-1:0]     w_victim_onehot;
    logic                  w_active;
    logic                  w_start;
    logic                  w_victim_ready;
    logic                  w_unused;

    // Victim search: strict less-than keeps the lowest index on TTL ties.
    always_comb begin
        w_min_idx = '0;
        w_min_ttl = line_ttl[TTLBITS-1:0];
        for (int i = 1; i < NLINES; i++) begin
            if (line_ttl[i*TTLBITS +: TTLBITS] < w_min_ttl) begin
                w_min_ttl = line_ttl[i*TTLBITS +: TTLBITS];
                w_min_idx = IDXBITS'(i);
            end
        end
    end

    generate
        for (genvar g = 0; g < NLINES; g++) begin : g_line
            assign w_min_onehot[g]      = (w_min_idx == IDXBITS'(g));
            assign w_victim_onehot[g]   = (r_victim  == IDXBITS'(g));
            assign line_pause[g]        = w_victim_onehot[g] & w_active & mem_pause;
            assign line_mem_in_valid[g] = w_victim_onehot[g] & w_active & mem_in_valid;
        end
    endgenerate

    assign w_active       = (r_state != S_IDLE);
    assign w_start        = miss_valid & (&line_miss) & (&line_ready);
    assign w_victim_ready = line_ready[r_victim];
    assign w_unused       = &{1'b0, miss_addr[LSBBITS-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_victim     <= '0;
            r_fill       <= '0;
            r_flush      <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_new_region <= '0;
        end else begin
            r_fill  <= '0;
            r_flush <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state      <= S_SELECT;
                        r_busy       <= 1'b1;
                        r_new_region <= {miss_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
                    end
                end
                S_SELECT: begin
                    // Commands are loaded here so they appear exactly during ISSUE.
                    r_victim <= w_min_idx;
                    r_fill   <= w_min_onehot;
                    r_flush  <= w_min_onehot & {NLINES{line_dirty[w_min_idx]}};
                    r_state  <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!w_victim_ready) begin
                        r_state <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    if (w_victim_ready) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign miss_busy  = r_busy;
    assign miss_done  = r_done;
    assign line_fill  = r_fill;
    assign line_flush = r_flush;
    assign new_region = r_new_region;

    // Only the victim's bus reaches memory, and nothing does while idle.
    assign mem_addr    = w_active ? line_mem_addr[r_victim*ADDRBITS +: ADDRBITS] : '0;
    assign mem_out     = w_active ? line_mem_out[r_victim*DATABITS +: DATABITS]  : '0;
    assign mem_rdreq   = w_active & line_mem_rdreq[r_victim];
    assign mem_wrreq   = w_active & line_mem_wrreq[r_victim];
    assign line_mem_in = mem_in;

    a_cmd_onehot: assert property (@(posedge clk) disable iff (!reset_n)
                                   $onehot0(line_fill | line_flush));

endmodule

`default_nettype wire

// File: tb/tb_cache_line_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_ctrl
//  Purpose  : Directed self-checking bench for cache_line_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_cache_line_ctrl;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          miss_valid;
    logic [31:0]   miss_addr;
    logic          miss_busy;
    logic          miss_done;
    logic [3:0]    line_miss;
    logic [3:0]    line_dirty;
    logic [3:0]    line_ready;
    logic [31:0]   line_ttl;
    logic [3:0]    line_flush;
    logic [3:0]    line_fill;
    logic [3:0]    line_pause;
    logic [31:0]   new_region;
    logic [127:0]  line_mem_addr;
    logic [127:0]  line_mem_out;
    logic [3:0]    line_mem_rdreq;
    logic [3:0]    line_mem_wrreq;
    logic [31:0]   line_mem_in;
    logic [3:0]    line_mem_in_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_out;
    logic          mem_rdreq;
    logic          mem_wrreq;
    logic [31:0]   mem_in;
    logic          mem_in_valid;
    logic          mem_pause;

    int n_checks = 0;
    int n_errors = 0;

    cache_line_ctrl #(
        .NLINES(4), .IDXBITS(2), .ADDRBITS(32), .DATABITS(32), .LSBBITS(7), .TTLBITS(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr),
        .miss_busy(miss_busy), .miss_done(miss_done),
        .line_miss(line_miss), .line_dirty(line_dirty), .line_ready(line_ready),
        .line_ttl(line_ttl), .line_flush(line_flush), .line_fill(line_fill),
        .line_pause(line_pause), .new_region(new_region),
        .line_mem_addr(line_mem_addr), .line_mem_out(line_mem_out),
        .line_mem_rdreq(line_mem_rdreq), .line_mem_wrreq(line_mem_wrreq),
        .line_mem_in(line_mem_in), .line_mem_in_valid(line_mem_in_valid),
        .mem_addr(mem_addr), .mem_out(mem_out), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
        .mem_in(mem_in), .mem_in_valid(mem_in_valid), .mem_pause(mem_pause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One refill from IDLE. Line i drives address A000_0i00 and data D000_000i,
    // rdreq=0101, wrreq=1010, so the victim's index fixes the expected bus values.
    // reset_at > 0 pulls reset_n that many cycles after ISSUE and abandons the refill.
    task automatic do_refill(input string tag, input logic [31:0] addr, input logic [31:0] ttl,
                             input logic [3:0] dirty, input logic [3:0] exp_fill,
                             input logic [3:0] exp_flush, input int idx,
                             input int fall_dly, input int rise_dly, input int reset_at);
        logic [31:0] exp_region;
        exp_region = {addr[31:7], 7'b0};
        line_ttl   = ttl;
        line_dirty = dirty;
        line_miss  = 4'hF;
        line_ready = 4'hF;
        miss_addr  = addr;
        miss_valid = 1'b1;
        tick();
        check({tag, " select busy"}, 32'(miss_busy), 32'd1);
        check({tag, " region"}, new_region, exp_region);
        check({tag, " no early fill"}, 32'(line_fill), 32'd0);
        miss_valid = 1'b0;
        tick();
        check({tag, " fill"}, 32'(line_fill), 32'(exp_fill));
        check({tag, " flush"}, 32'(line_flush), 32'(exp_flush));
        for (int k = 1; k <= rise_dly; k++) begin
            tick();
            if (k == 1) begin
                check({tag, " fill pulse ends"}, 32'(line_fill | line_flush), 32'd0);
            end
            if (k == 2) begin
                mem_in       = 32'hCAFE_0000 | 32'(idx);
                mem_in_valid = 1'b1;
                mem_pause    = 1'b1;
                #1;
                check({tag, " in_valid"}, 32'(line_mem_in_valid), 32'(exp_fill));
                check({tag, " pause"}, 32'(line_pause), 32'(exp_fill));
                check({tag, " mem_in bcast"}, line_mem_in, 32'hCAFE_0000 | 32'(idx));
                check({tag, " mem_addr"}, mem_addr, 32'hA000_0000 | 32'(idx << 8));
                check({tag, " mem_out"}, mem_out, 32'hD000_0000 | 32'(idx));
                check({tag, " mem_rdreq"}, 32'(mem_rdreq), 32'(idx % 2 == 0));
                check({tag, " mem_wrreq"}, 32'(mem_wrreq), 32'(idx % 2 == 1));
                mem_in_valid = 1'b0;
                mem_pause    = 1'b0;
            end
            if (k == reset_at) begin
                mem_pause    = 1'b1;
                mem_in_valid = 1'b1;
                reset_n      = 1'b0;
                #1;
                check({tag, " rst busy"}, 32'(miss_busy), 32'd0);
                check({tag, " rst done"}, 32'(miss_done), 32'd0);
                check({tag, " rst region"}, new_region, 32'd0);
                check({tag, " rst pause"}, 32'(line_pause), 32'd0);
                check({tag, " rst in_valid"}, 32'(line_mem_in_valid), 32'd0);
                check({tag, " rst mem req"}, {mem_addr[29:0], mem_rdreq, mem_wrreq}, 32'd0);
                mem_pause    = 1'b0;
                mem_in_valid = 1'b0;
                line_ready   = 4'hF;
                tick();
                tick();
                reset_n = 1'b1;
                tick();
                return;
            end
            if (k == fall_dly) line_ready = line_ready & ~exp_fill;
            if (k == rise_dly) begin
                check({tag, " no early done"}, 32'(miss_done), 32'd0);
                check({tag, " busy in wait"}, 32'(miss_busy), 32'd1);
                line_ready = 4'hF;
            end
        end
        tick();
        check({tag, " done pulse"}, 32'(miss_done), 32'd1);
        tick();
        check({tag, " done clears"}, 32'(miss_done), 32'd0);
        check({tag, " back to idle"}, 32'(miss_busy), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        miss_valid     = 1'b0;
        miss_addr      = 32'h0;
        line_miss      = 4'h0;
        line_dirty     = 4'h0;
        line_ready     = 4'hF;
        line_ttl       = 32'h0;
        line_mem_addr  = {32'hA000_0300, 32'hA000_0200, 32'hA000_0100, 32'hA000_0000};
        line_mem_out   = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        line_mem_rdreq = 4'b0101;
        line_mem_wrreq = 4'b1010;
        mem_in         = 32'h0;
        mem_in_valid   = 1'b0;
        mem_pause      = 1'b0;

        tick();
        tick();
        check("reset busy", 32'(miss_busy), 32'd0);
        check("reset cmds", 32'(line_fill | line_flush), 32'd0);
        check("reset region", new_region, 32'd0);
        reset_n = 1'b1;
        tick();

        // Idle: memory port silent, read data broadcast, valid and pause dropped.
        mem_in       = 32'h5555_AAAA;
        mem_in_valid = 1'b1;
        mem_pause    = 1'b1;
        #1;
        check("idle in_valid", 32'(line_mem_in_valid), 32'd0);
        check("idle pause", 32'(line_pause), 32'd0);
        check("idle mem_in", line_mem_in, 32'h5555_AAAA);
        check("idle mem req", {mem_addr[29:0], mem_rdreq, mem_wrreq}, 32'd0);
        mem_in_valid = 1'b0;
        mem_pause    = 1'b0;

        // Victim line1 (ttl 10), clean, long refill.
        do_refill("t1", 32'h1234_5678, {8'd20, 8'd30, 8'd10, 8'd40}, 4'b0000,
                  4'b0010, 4'b0000, 1, 3, 40, 0);
        // Tie 10/10 -> line0, dirty, non-victim line3 also dirty.
        do_refill("t2", 32'h0000_00FF, {8'd50, 8'd50, 8'd10, 8'd10}, 4'b1001,
                  4'b0001, 4'b0001, 0, 2, 6, 0);

        // A hit, and an all-miss with a line not ready: neither starts a refill.
        line_miss  = 4'b1101;
        miss_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("hit no busy", 32'(miss_busy), 32'd0);
            check("hit no cmd", 32'(line_fill | line_flush), 32'd0);
        end
        line_miss  = 4'hF;
        line_ready = 4'b1110;
        tick();
        tick();
        check("not ready no busy", 32'(miss_busy), 32'd0);
        miss_valid = 1'b0;
        line_ready = 4'hF;
        tick();

        // Tie 7/7 between lines 2 and 3 -> line2, dirty.
        do_refill("t4", 32'hFFFF_FFFF, {8'd7, 8'd7, 8'd50, 8'd50}, 4'b0100,
                  4'b0100, 4'b0100, 2, 2, 5, 0);
        // Highest index holds the minimum.
        do_refill("t5", 32'h8000_0080, {8'd1, 8'd200, 8'd200, 8'd200}, 4'b0111,
                  4'b1000, 4'b0000, 3, 4, 9, 0);
        // Reset while waiting for ready, then a normal refill afterwards.
        do_refill("t6", 32'h0F0F_0F0F, {8'd20, 8'd30, 8'd10, 8'd40}, 4'b0000,
                  4'b0010, 4'b0000, 1, 3, 40, 10);
        do_refill("t6b", 32'h0000_1280, {8'd90, 8'd3, 8'd90, 8'd90}, 4'b0100,
                  4'b0100, 4'b0100, 2, 3, 7, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
